// File: rtl/irq_pkg.sv
// Shared constants, types and the priority encoder for the 68000 interrupt controller.
// Used by irq_sync and irq_ctrl; the IRQ_SYNC_EN build option lives in irq_sync.
package irq_pkg;

  localparam int unsigned NUM_LEVELS = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LEVEL_W    = 3;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_LEVEL   = 2'd3;

  localparam logic [2:0] FC_IACK = 3'b111;

  // Bit 7 of every register is reserved and always reads zero.
  localparam logic [DATA_W-1:0] REG_BITS = 8'h7F;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic {
    IACK_IDLE,
    IACK_ACTIVE
  } iack_state_t;

  // Highest set request bit i maps to level i+1; no request gives level 0.
  function automatic level_t prio_level(input logic [NUM_LEVELS-1:0] req);
    level_t lvl;
    lvl = '0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      if (req[i]) lvl = LEVEL_W'(i + 1);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-bit request conditioning: optional two-flop synchroniser (IRQ_SYNC_EN)
// followed by a previous-value flop, giving the conditioned level and a rise pulse.
module irq_sync
  import irq_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_LEVELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] sync_c,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] prev_q;

`ifdef IRQ_SYNC_EN
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      stage_q <= '0;
    end else begin
      meta_q  <= src;
      stage_q <= meta_q;
    end
  end

  assign sync_c = stage_q;
`else
  // Sources are already synchronous to clk.
  assign sync_c = src;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sync_c;
  end

  assign rise_c = sync_c & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// 68000 interrupt controller: PENDING/MASK/EDGE/LEVEL registers, priority encode to
// IPL, IACK autovector on vpa_n. Define IRQ_SYNC_EN for asynchronous sources.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_MASK = 8'h00,
  parameter logic [DATA_W-1:0] RESET_EDGE = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  rw_n,
  input  logic [1:0]            addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  input  logic [NUM_LEVELS-1:0] src,
  input  logic                  as_n,
  input  logic [2:0]            fc,
  input  logic [LEVEL_W-1:0]    ack_lvl,
  output logic [LEVEL_W-1:0]    ipl_n,
  output logic                  vpa_n
);

  logic [NUM_LEVELS-1:0] src_sync_c;
  logic [NUM_LEVELS-1:0] src_rise_c;

  logic [DATA_W-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] edge_mode_q;

  logic [DATA_W-1:0] w1c_c;
  logic [DATA_W-1:0] iack_clr_c;
  logic              wr_en_c;
  logic              iack_c;
  logic              iack_first_c;
  level_t            level_c;

  iack_state_t state_q, state_d;

  irq_sync #(.WIDTH(NUM_LEVELS)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .src    (src),
    .sync_c (src_sync_c),
    .rise_c (src_rise_c)
  );

  assign wr_en_c = cs && !rw_n;
  assign iack_c  = (fc == FC_IACK) && !as_n && (ack_lvl != '0);

  // IACK tracker: one clear per acknowledge cycle, held until the strobe releases.
  always_comb begin
    state_d      = state_q;
    iack_first_c = 1'b0;
    case (state_q)
      IACK_IDLE: begin
        if (iack_c) begin
          state_d      = IACK_ACTIVE;
          iack_first_c = 1'b1;
        end
      end
      IACK_ACTIVE: begin
        if (as_n) state_d = IACK_IDLE;
      end
      default: state_d = IACK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IACK_IDLE;
    else     state_q <= state_d;
  end

  // Pending next state: a rise always wins over W1C and IACK clears.
  always_comb begin
    w1c_c      = '0;
    iack_clr_c = '0;
    if (wr_en_c && (addr == REG_PENDING)) w1c_c = din;
    if (iack_first_c) iack_clr_c = DATA_W'(1) << (ack_lvl - LEVEL_W'(1));
    pending_d = REG_BITS &
                ((edge_mode_q & ({1'b0, src_rise_c} | (pending_q & ~w1c_c & ~iack_clr_c))) |
                 (~edge_mode_q & {1'b0, src_sync_c}));
  end

  assign level_c = prio_level(pending_q[NUM_LEVELS-1:0] & mask_q[NUM_LEVELS-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      mask_q      <= RESET_MASK & REG_BITS;
      edge_mode_q <= RESET_EDGE & REG_BITS;
      ipl_n       <= '1;
      vpa_n       <= 1'b1;
    end else begin
      pending_q <= pending_d;
      if (wr_en_c && (addr == REG_MASK)) mask_q      <= din & REG_BITS;
      if (wr_en_c && (addr == REG_EDGE)) edge_mode_q <= din & REG_BITS;
      ipl_n <= ~level_c;
      vpa_n <= (state_q != IACK_ACTIVE);
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      REG_PENDING: dout = pending_q;
      REG_MASK:    dout = mask_q;
      REG_EDGE:    dout = edge_mode_q;
      REG_LEVEL:   dout = {5'b0, level_c};
      default:     dout = '0;
    endcase
  end

endmodule
